// File: rtl/ritc_dac_serial_tx.sv
// Serial frame transmitter for the RITC DAC/register port: shifts a 16-bit {addr,data}
// word MSB-first on SCLK/DIN, then strobes LATCH and waits a guard gap before the next frame.
module ritc_dac_serial_tx #(
  parameter int HALF_PERIOD = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        disable_i,
  input  logic [3:0]  addr_i,
  input  logic [11:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        SCLK_o,
  output logic        DIN_o,
  output logic        LATCH_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int HW = $clog2(HALF_PERIOD + 1);
  localparam logic [HW-1:0] HLAST = HW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  logic          r_phase, w_phase_nxt;
  logic [4:0]    r_bit, w_bit_nxt;
  logic [15:0]   r_shreg, w_shreg_nxt;
  logic          r_sclk, r_din, r_latch, r_busy, r_done;
  logic          w_sclk_nxt, w_din_nxt, w_latch_nxt, w_busy_nxt, w_done_nxt;
  logic          w_hend, w_accept;

  assign ready_o  = (r_state == IDLE) & ~disable_i;
  assign w_accept = valid_i & ready_o;
  assign w_hend   = (r_hcnt == HLAST);

  assign SCLK_o  = r_sclk;
  assign DIN_o   = r_din;
  assign LATCH_o = r_latch;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_sclk  <= 1'b0;
      r_din   <= 1'b0;
      r_latch <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_sclk  <= w_sclk_nxt;
      r_din   <= w_din_nxt;
      r_latch <= w_latch_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // r_phase selects the low (0) or high (1) half of an SCLK period; LATCH reuses it for 2 halves.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state_nxt = SHIFT;
        w_hcnt_nxt  = '0;
        w_phase_nxt = 1'b0;
        w_bit_nxt   = '0;
        w_shreg_nxt = {addr_i, data_i};
      end
      SHIFT: if (w_hend) begin
        w_hcnt_nxt  = '0;
        w_phase_nxt = ~r_phase;
        if (r_phase) begin
          w_shreg_nxt = {r_shreg[14:0], 1'b0};
          if (r_bit == 5'd15) begin
            w_state_nxt = LATCH;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + 5'd1;
          end
        end
      end else begin
        w_hcnt_nxt = r_hcnt + HW'(1);
      end
      LATCH: if (w_hend) begin
        w_hcnt_nxt  = '0;
        w_phase_nxt = ~r_phase;
        if (r_phase) w_state_nxt = GAP;
      end else begin
        w_hcnt_nxt = r_hcnt + HW'(1);
      end
      GAP: if (w_hend) begin
        w_hcnt_nxt  = '0;
        w_state_nxt = IDLE;
      end else begin
        w_hcnt_nxt = r_hcnt + HW'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the flops line up with the state register.
  always_comb begin
    w_sclk_nxt  = (w_state_nxt == SHIFT) & w_phase_nxt;
    w_din_nxt   = (w_state_nxt == SHIFT) & w_shreg_nxt[15];
    w_latch_nxt = (w_state_nxt == LATCH);
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_done_nxt  = (r_state == GAP) & (w_state_nxt == IDLE);
  end

endmodule

// File: doc/ritc_dac_serial_tx.md
RITC_DAC_SERIAL_TX -- requirements
Module: ritc_dac_serial_tx

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4, meaning clk_i cycles per SCLK half-period; legal range 1..255.
REQ-002 SHALL have port clk_i, input, 1, the single system clock; all logic is in this domain.
REQ-003 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port disable_i, input, 1, which blocks acceptance of new frames while high.
REQ-005 SHALL have port addr_i, input, 4, the RITC DAC/register address of the frame.
REQ-006 SHALL have port data_i, input, 12, the DAC/register value of the frame.
REQ-007 SHALL have port valid_i, input, 1, the frame request qualifier.
REQ-008 SHALL have port ready_o, output, 1, which is high when a frame can be accepted.
REQ-009 SHALL have port SCLK_o, output, 1, the serial clock to the RITC.
REQ-010 SHALL have port DIN_o, output, 1, the serial data to the RITC.
REQ-011 SHALL have port LATCH_o, output, 1, the load strobe to the RITC.
REQ-012 SHALL have port busy_o, output, 1, which is high whenever the state is not IDLE.
REQ-013 SHALL have port done_o, output, 1, a one-cycle completion pulse.

Function
REQ-014 SHALL make SCLK_o, DIN_o, LATCH_o, busy_o and done_o flop outputs with no combinational path from any input.
REQ-015 SHALL drive ready_o = (state==IDLE) & ~disable_i.
REQ-016 SHALL accept a frame on a rising clk_i edge where valid_i & ready_o, capturing shift register = {addr_i, data_i} (16 bits); valid_i without ready_o SHALL be ignored, with no queuing.
REQ-017 SHALL use states IDLE -> SHIFT (on accept) -> LATCH (after 16 bits) -> GAP (after 2*HALF_PERIOD cycles) -> IDLE (after HALF_PERIOD cycles); no other transitions except reset.
REQ-018 SHALL shift MSB first (addr[3] first, data[0] last).
REQ-019 In SHIFT, SHALL present each bit on DIN_o for 2*HALF_PERIOD cycles: SCLK_o low for the first HALF_PERIOD cycles, high for the second; DIN_o changes only while SCLK_o is low, on the first cycle of each bit.
REQ-020 SHALL drive the first DIN_o bit in the cycle immediately after the accept edge; SHIFT lasts exactly 32*HALF_PERIOD cycles.
REQ-021 SHALL hold SCLK_o low and DIN_o at 0 in IDLE, LATCH and GAP.
REQ-022 SHALL hold LATCH_o high for exactly the 2*HALF_PERIOD cycles of LATCH, and low otherwise.
REQ-023 SHALL pulse done_o high for exactly one cycle: the first IDLE cycle after GAP; ready_o may be high in that same cycle, allowing back-to-back frames.
REQ-024 SHALL make the accept-to-done latency exactly 35*HALF_PERIOD+1 cycles (141 at the default).
REQ-025 SHALL let a frame in progress complete normally if disable_i asserts mid-frame; disable_i affects only acceptance.
REQ-026 SHALL use a half-period counter of width ceil(log2(HALF_PERIOD+1)) and a bit counter of width 5, with no wrap beyond their terminal counts.

Reset
REQ-027 SHALL, while rst_n_i is low, immediately (asynchronously) force state IDLE, SCLK_o=0, DIN_o=0, LATCH_o=0, busy_o=0, done_o=0, and clear the shift register and counters.
REQ-028 SHALL abort any frame when reset occurs mid-operation, with no partial LATCH_o pulse and no done_o.
REQ-029 SHALL make ready_o high in the first cycle after rst_n_i deasserts if disable_i is low.

Verification
REQ-030 Single frame, HALF_PERIOD=4, addr=0xA, data=0x5C3: bench SHALL check 16 SCLK rising edges sampling DIN bits 1010_0101_1100_0011, LATCH high 8 cycles, and done 141 cycles after accept.
REQ-031 Back-to-back frames: valid_i held high with two frames: bench SHALL check the second accept in the done_o cycle and no SCLK edge inside LATCH or GAP.
REQ-032 disable_i high with valid_i high: bench SHALL check ready_o=0, no accept and SCLK idle; with disable_i asserted mid-SHIFT, the frame SHALL complete and done_o SHALL pulse once.
REQ-033 rst_n_i pulsed low during bit 7 of SHIFT: bench SHALL check all outputs 0 asynchronously, LATCH_o never asserted and done_o absent.
REQ-034 HALF_PERIOD=1: bench SHALL check that SCLK toggles every cycle and the latency is 36 cycles.
